// File: rtl/frog_pkg.sv
// frog_pkg: shared state codes, playfield defaults and direction bit encoding for the frog controller
package frog_pkg;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PLAY = 3'd1,
    S_DEAD = 3'd2,
    S_WIN  = 3'd3,
    S_OVER = 3'd4
  } state_t;
  localparam int DEF_CELL_PX   = 40;
  localparam int DEF_GRID_COLS = 16;
  localparam int DEF_GRID_ROWS = 12;
  // bit positions in the {SW4,SW3,SW2,SW1} press vector; priority is UP > DOWN > LEFT > RIGHT
  typedef enum logic [1:0] {
    DIR_DOWN  = 2'd0,
    DIR_UP    = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_t;
endpackage

// File: rtl/frog_sw_sync.sv
// frog_sw_sync: 2-FF synchronizer for four switches plus frame-sampled press detection
module frog_sw_sync (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       FRAME_TICK,
  input  logic [3:0] sw,
  input  logic       rep,
  output logic [3:0] press
);
  logic [3:0] s1, s2, samp;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      s1   <= '0;
      s2   <= '0;
      samp <= '0;
    end else begin
      s1 <= sw;
      s2 <= s1;
      if (FRAME_TICK) samp <= s2;
    end
  // rep turns the edge detector into a level pass-through for hold-to-repeat
  assign press = FRAME_TICK ? (s2 & (rep ? 4'hf : ~samp)) : '0;
endmodule

// File: rtl/frog_hop_ctrl.sv
// frog_hop_ctrl: frame-ticked frog hop/life/score sequencer publishing sprite pixel position
// Optional FROG_HOLD_REPEAT_EN: a held switch re-hops each time the cooldown expires.
module frog_hop_ctrl
  import frog_pkg::*;
#(
  parameter int CELL_PX      = DEF_CELL_PX,
  parameter int GRID_COLS    = DEF_GRID_COLS,
  parameter int GRID_ROWS    = DEF_GRID_ROWS,
  parameter int START_COL    = 7,
  parameter int START_ROW    = 11,
  parameter int LIVES_INIT   = 3,
  parameter int HOP_FRAMES   = 8,
  parameter int PAUSE_FRAMES = 60
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       FRAME_TICK,
  input  logic       SW1,
  input  logic       SW2,
  input  logic       SW3,
  input  logic       SW4,
  input  logic       HIT,
  output logic [9:0] PLAYER_X,
  output logic [9:0] PLAYER_Y,
  output logic [2:0] STATE,
  output logic [2:0] LIVES,
  output logic [7:0] SCORE
);
  localparam int CW = $clog2(HOP_FRAMES + 1);
  localparam int PW = $clog2(PAUSE_FRAMES + 1);
  state_t st, st_n;
  logic [3:0] col, row, col_n, row_n, nc, nr, press, req;
  logic [2:0] lives, lives_n;
  logic [7:0] score, score_n;
  logic [CW-1:0] cd, cd_n;
  logic [PW-1:0] pz, pz_n;
  logic rep, go;
`ifdef FROG_HOLD_REPEAT_EN
  assign rep = (st == S_PLAY) && (cd == CW'(1));
`else
  assign rep = 1'b0;
`endif
  frog_sw_sync u_sync (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .FRAME_TICK (FRAME_TICK),
    .sw         ({SW4, SW3, SW2, SW1}),
    .rep        (rep),
    .press      (press)
  );
  assign req = (cd == '0 || rep) ? press : '0;
  // only the highest-priority request is considered; if it leaves the grid, nothing moves
  always_comb begin
    nc = col;
    nr = row;
    go = 1'b0;
    if (req[DIR_UP]) begin
      go = row != 4'd0;
      nr = row - 4'd1;
    end else if (req[DIR_DOWN]) begin
      go = row != 4'(GRID_ROWS - 1);
      nr = row + 4'd1;
    end else if (req[DIR_LEFT]) begin
      go = col != 4'd0;
      nc = col - 4'd1;
    end else if (req[DIR_RIGHT]) begin
      go = col != 4'(GRID_COLS - 1);
      nc = col + 4'd1;
    end
  end
  always_comb begin
    st_n    = st;
    col_n   = col;
    row_n   = row;
    lives_n = lives;
    score_n = score;
    cd_n    = cd;
    pz_n    = pz;
    if (FRAME_TICK)
      case (st)
        S_IDLE: st_n = |press ? S_PLAY : S_IDLE;
        S_PLAY:
          if (HIT) begin
            st_n    = S_DEAD;
            lives_n = lives - 3'd1;
          end else begin
            cd_n = (cd != '0) ? cd - CW'(1) : cd;
            if (go) begin
              col_n = nc;
              row_n = nr;
              cd_n  = CW'(HOP_FRAMES);
              if (nr == 4'd0) begin
                st_n    = S_WIN;
                score_n = (score == 8'hff) ? score : score + 8'd1;
              end
            end
          end
        S_DEAD, S_WIN: begin
          pz_n = pz + PW'(1);
          if (pz == PW'(PAUSE_FRAMES - 1)) begin
            pz_n = '0;
            if (st == S_DEAD && lives == 3'd0) st_n = S_OVER;
            else begin
              st_n  = S_PLAY;
              col_n = 4'(START_COL);
              row_n = 4'(START_ROW);
              cd_n  = '0;
            end
          end
        end
        S_OVER:
          if (|press) begin
            st_n    = S_IDLE;
            col_n   = 4'(START_COL);
            row_n   = 4'(START_ROW);
            lives_n = 3'(LIVES_INIT);
            score_n = '0;
            cd_n    = '0;
          end
        default: st_n = S_IDLE;
      endcase
  end
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      st       <= S_IDLE;
      col      <= 4'(START_COL);
      row      <= 4'(START_ROW);
      lives    <= 3'(LIVES_INIT);
      score    <= '0;
      cd       <= '0;
      pz       <= '0;
      PLAYER_X <= 10'(START_COL * CELL_PX);
      PLAYER_Y <= 10'(START_ROW * CELL_PX);
    end else begin
      st       <= st_n;
      col      <= col_n;
      row      <= row_n;
      lives    <= lives_n;
      score    <= score_n;
      cd       <= cd_n;
      pz       <= pz_n;
      PLAYER_X <= 10'(col_n) * 10'(CELL_PX);
      PLAYER_Y <= 10'(row_n) * 10'(CELL_PX);
    end
  assign STATE = st;
  assign LIVES = lives;
  assign SCORE = score;
endmodule
